// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main controller for a multicycle RV32I-subset datapath (lw, sw, R-type,
// I-type ALU, beq, jal). A Moore FSM steps each instruction through its
// fetch/decode/execute/writeback states. The ALU decoder and immediate-format
// decoder are combinational off the instruction fields. Unsupported opcodes
// abort back to FETCH and set a sticky illegal flag.
//
// Ports
//   clk         in   1  clock, all state updates on the rising edge
//   reset       in   1  synchronous active-high reset
//   op          in   7  opcode from the instruction register
//   funct3      in   3  instruction funct3
//   funct7      in   1  instruction bit 30 (funct7[5])
//   zero        in   1  ALU zero flag (drives PCWrite in BEQ)
//   mem_ready   in   1  1 = current memory access completes this cycle
//   PCWrite     out  1  PC write enable
//   IRWrite     out  1  instruction register write enable
//   RegWrite    out  1  register file write enable
//   MemWrite    out  1  data memory write enable
//   AdrSrc      out  1  memory address select (0 PC, 1 ALUOut)
//   ResultSrc   out  2  00 ALUOut, 01 memory data, 10 ALU result
//   ALUSrcA     out  2  00 PC, 01 OldPC, 10 rs1 data
//   ALUSrcB     out  2  00 rs2 data, 01 immediate, 10 constant 4
//   Immsrc      out  2  00 I, 01 S, 10 B, 11 J
//   ALUControl  out  3  ALU operation select
//   illegal     out  1  sticky: an unsupported opcode was decoded
//   instr_done  out  1  pulse on the last state of each instruction
// -----------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] Immsrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic       instr_done
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;

  logic       op_legal;

  // Raw per-state controls before reset gating / branch resolution
  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       mem_write_raw;
  logic       done_raw;
  logic [1:0] alu_op;

  // ---------------------------------------------------------------------------
  // State and sticky flag registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: op_legal = 1'b1;
      default:                                              op_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded controls. The handshake-qualified strobes in FETCH and
  // MEMWRITE follow mem_ready so the PC/IR only update on a completed fetch.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    done_raw      = 1'b0;
    alu_op        = 2'b00;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      S_DECODE: begin
        // OldPC + imm precomputes the branch/jump target into ALUOut
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b01;
        done_raw = ~op_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        alu_op  = 2'b10;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = mem_ready;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b00;
        alu_op   = 2'b01;
        branch   = 1'b1;
        done_raw = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: begin
        pc_update = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Immediate format, decoded from the opcode in every state
  // ---------------------------------------------------------------------------
  always_comb begin
    Immsrc = 2'b00;
    case (op)
      OP_STORE: Immsrc = 2'b01;
      OP_BEQ:   Immsrc = 2'b10;
      OP_JAL:   Immsrc = 2'b11;
      default:  Immsrc = 2'b00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU decoder. funct7 only selects subtract for R-type (op[5]=1), so addi
  // with bit 30 set still adds.
  // ---------------------------------------------------------------------------
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (funct7 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Enables and completion pulse are suppressed while reset is held so nothing
  // architectural changes during the reset cycle.
  // ---------------------------------------------------------------------------
  assign PCWrite    = ~reset & (pc_update | (branch & zero));
  assign IRWrite    = ~reset & ir_write_raw;
  assign RegWrite   = ~reset & reg_write_raw;
  assign MemWrite   = ~reset & mem_write_raw;
  assign instr_done = ~reset & done_raw;
  assign illegal    = illegal_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths and encodings are fixed as stated below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  7  instruction opcode from the instruction register.
REQ-005 funct3  input  3  instruction funct3.
REQ-006 funct7  input  1  instruction bit 30 (funct7[5]).
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory handshake; 1 = the current access completes this cycle.
REQ-009 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  output  1 each  PC/IR/regfile/memory write enables and address select (0 = PC, 1 = ALUOut).
REQ-010 ResultSrc  output  2  00 ALUOut, 01 memory data, 10 ALU result.
REQ-011 ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 data; ALUSrcB  output  2  00 rs2 data, 01 immediate, 10 constant 4.
REQ-012 Immsrc  output  2  00 I, 01 S, 10 B, 11 J; ALUControl  output  3.
REQ-013 illegal  output  1  sticky flag: an unsupported opcode was decoded.
REQ-014 instr_done  output  1  one-cycle pulse on the last state of each instruction.

Function
REQ-015 The FSM SHALL have the states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-016 Transitions: FETCH->DECODE only when mem_ready=1, otherwise hold in FETCH.
REQ-017 DECODE transitions: op 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BEQ; 1101111->JAL; any other op->FETCH with illegal set to 1.
REQ-018 MEMADR->MEMREAD if op=0000011, else MEMWRITE.
REQ-019 MEMREAD->MEMWB and MEMWRITE->FETCH only when mem_ready=1, else hold.
REQ-020 MEMWB->FETCH; EXECR/EXECI->ALUWB; ALUWB->FETCH; JAL->ALUWB; BEQ->FETCH.
REQ-021 Outputs SHALL be Moore, decoded from state; the only exception is PCWrite = PCUpdate | (Branch & zero), which SHALL be combinational on zero.
REQ-022 FETCH: AdrSrc=0, IRWrite=mem_ready, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=mem_ready.
REQ-023 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-024 MEMADR/EXECI: ALUSrcA=10, ALUSrcB=01; ALUOp is 00 in MEMADR and 10 in EXECI.
REQ-025 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
REQ-026 MEMREAD: ResultSrc=00, AdrSrc=1.
REQ-027 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held for every cycle in the state.
REQ-028 MEMWB: ResultSrc=01, RegWrite=1; ALUWB: ResultSrc=00, RegWrite=1.
REQ-029 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
REQ-030 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-031 Unlisted outputs SHALL be 0 in every state.
REQ-032 Immsrc SHALL be decoded from op in every state: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, other->00.
REQ-033 ALUControl rules: ALUOp 00->000 (add); ALUOp 01->001 (sub).
REQ-034 ALUControl rules for ALUOp 10, by funct3: 000->001 if funct7 & op[5], else 000; 010->101; 110->011; 111->010; other->000.
REQ-035 instr_done SHALL be 1 in MEMWB, ALUWB, BEQ, and in MEMWRITE when mem_ready=1; it SHALL also pulse in DECODE on an illegal opcode.
REQ-036 illegal SHALL remain 1 until reset.

Reset
REQ-037 reset=1 at a rising edge SHALL force state=FETCH and illegal=0, regardless of current state, including mid-stall.
REQ-038 While reset=1, PCWrite, IRWrite, RegWrite, MemWrite and instr_done SHALL be forced to 0.
REQ-039 The first fetch SHALL occur in the first cycle after reset deasserts.

Verification
REQ-040 lw, mem_ready=1: states FETCH,DECODE,MEMADR,MEMREAD,MEMWB (5 cycles); MEMWB gives RegWrite=1, ResultSrc=01; Immsrc=00 and ALUControl=000 throughout.
REQ-041 sw, mem_ready low 3 cycles in MEMWRITE: MemWrite=1 for 4 cycles, AdrSrc=1, Immsrc=01, RegWrite=0, instr_done=1 only on the final cycle.
REQ-042 beq, zero=1 then zero=0: in BEQ, PCWrite=1 and ALUControl=001 for zero=1; PCWrite=0 for zero=0; both return to FETCH.
REQ-043 R-type sub (funct3=000, funct7=1) -> EXECR ALUControl=001; addi (op=0010011, funct3=000, funct7=1) -> EXECI ALUControl=000; then ALUWB with RegWrite=1.
REQ-044 jal: states FETCH,DECODE,JAL,ALUWB; JAL state has PCWrite=1, Immsrc=11, ALUSrcA=01, ALUSrcB=10.
REQ-045 op=1111111 -> DECODE->FETCH with illegal=1 sticky; reset asserted during a MEMREAD stall -> next state FETCH, illegal=0, all write enables 0.
